// File: rtl/huffman_frame_ctrl_if.sv
// Symbol-stream and encoder-side signals of the Huffman frame sequencer.
// The controller sits on the slave modport; the upstream source and the encoder model sit on master.
interface huffman_frame_ctrl_if #(
  parameter int SYM_W = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [SYM_W-1:0] s_data;
  logic             s_last;
  logic             enc_start;
  logic             enc_start_done;
  logic [SYM_W-1:0] enc_data_in;
  logic             enc_output_start;
  logic             enc_output_data;
  logic             enc_output_done;

  modport slave (
    input  s_valid, s_data, s_last,
    input  enc_output_start, enc_output_data, enc_output_done,
    output s_ready, enc_start, enc_start_done, enc_data_in
  );

  modport master (
    output s_valid, s_data, s_last,
    output enc_output_start, enc_output_data, enc_output_done,
    input  s_ready, enc_start, enc_start_done, enc_data_in
  );
endinterface

// File: rtl/huffman_frame_ctrl.sv
// Buffers one frame of symbols, replays it gap-free to the Huffman encoder, then
// supervises the serial output phase and reports per-frame symbol/bit statistics.
module huffman_frame_ctrl #(
  parameter int SYM_W      = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int BITS_W     = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  huffman_frame_ctrl_if.slave           bus,
  output logic                          o_busy,
  output logic                          o_frame_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_frame_syms,
  output logic [BITS_W-1:0]             o_frame_bits,
  output logic                          o_err_trunc,
  output logic                          o_err_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    COLLECT, START, STREAM, WAIT_OUT, SHIFT, REPORT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SYM_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, r_syms;
  logic              r_trunc;
  logic [BITS_W-1:0] r_bit_cnt, w_bit_nxt;
  logic [TW-1:0]     r_tmo;
  logic [CW-1:0]     r_frame_syms;
  logic [BITS_W-1:0] r_frame_bits;
  logic              r_frame_trunc;

  logic w_full, w_push, w_fill, w_close;
  logic w_in_out, w_tmo, w_out_start, w_out_done, w_bit_upd;
  logic w_unused_obit;

  // The serial bit value is only observed, never interpreted.
  assign w_unused_obit = bus.enc_output_data;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = (r_state == COLLECT) && bus.s_valid && !w_full;
  assign w_fill      = w_push && (r_count == CW'(FIFO_DEPTH - 1));
  assign w_close     = w_push && (bus.s_last || w_fill);
  assign w_in_out    = (r_state == WAIT_OUT) || (r_state == SHIFT);
  assign w_tmo       = w_in_out && (r_tmo == TW'(TIMEOUT - 1));
  assign w_out_start = (r_state == WAIT_OUT) && bus.enc_output_start;
  assign w_out_done  = (w_out_start && bus.enc_output_done) ||
                       ((r_state == SHIFT) && bus.enc_output_done);
  assign w_bit_upd   = w_out_start || (r_state == SHIFT);

  always_comb begin
    w_bit_nxt = r_bit_cnt;
    if (r_state == WAIT_OUT)
      w_bit_nxt = BITS_W'(1);
    else if (r_bit_cnt != '1)
      w_bit_nxt = r_bit_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  // Timeout takes priority over a completion landing on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT:  if (w_close) w_state_nxt = START;
      START:    w_state_nxt = STREAM;
      STREAM:   if (r_count == CW'(1)) w_state_nxt = WAIT_OUT;
      WAIT_OUT: begin
        if (w_tmo)            w_state_nxt = COLLECT;
        else if (w_out_start) w_state_nxt = bus.enc_output_done ? REPORT : SHIFT;
      end
      SHIFT: begin
        if (w_tmo)                     w_state_nxt = COLLECT;
        else if (bus.enc_output_done)  w_state_nxt = REPORT;
      end
      REPORT:   w_state_nxt = COLLECT;
      default:  w_state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    bus.s_ready        = 1'b0;
    bus.enc_start      = 1'b0;
    bus.enc_start_done = 1'b0;
    bus.enc_data_in    = '0;
    o_busy             = (r_state != COLLECT);
    o_frame_valid      = (r_state == REPORT);
    o_err_timeout      = w_tmo;
    o_frame_syms       = r_frame_syms;
    o_frame_bits       = r_frame_bits;
    o_err_trunc        = r_frame_trunc;
    unique case (r_state)
      COLLECT: bus.s_ready = !w_full;
      START:   bus.enc_start = 1'b1;
      STREAM: begin
        bus.enc_data_in    = r_mem[r_rd_ptr];
        bus.enc_start_done = (r_count == CW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_syms        <= '0;
      r_trunc       <= 1'b0;
      r_bit_cnt     <= '0;
      r_tmo         <= '0;
      r_frame_syms  <= '0;
      r_frame_bits  <= '0;
      r_frame_trunc <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
      // Only the closing push decides truncation: a fill that carries s_last is a clean frame.
      if (w_close)             r_trunc <= !bus.s_last;
      if (r_state == START)    r_syms  <= r_count;
      if (r_state == STREAM) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= r_count - 1'b1;
        r_tmo    <= '0;
      end
      if (w_in_out)  r_tmo     <= r_tmo + 1'b1;
      if (w_bit_upd) r_bit_cnt <= w_bit_nxt;
      if (w_out_done && !w_tmo) begin
        r_frame_syms  <= r_syms;
        r_frame_bits  <= w_bit_nxt;
        r_frame_trunc <= r_trunc;
      end
      if (w_tmo) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end
    end
  end
endmodule
